eff_echo: RTL and testbench

//  Feedback echo (delay) stage inside the effects pipe, on the mclk domain.

---
 rtl/eff_echo.sv | 164 ++++++++++++++++
 tb/tb_eff_echo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eff_echo.sv
// Feedback echo stage: y[n] = x[n] + (gain * y[n-delay]) >> GAIN_W, with y written back to a BRAM ring.
// Optional macro ECHO_SAT_EN saturates the sum instead of wrapping it.
module eff_echo #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 12,
   parameter int GAIN_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] delay,
   input  logic [GAIN_W-1:0] gain,
   input  logic [DATA_W-1:0] data_i,
   input  logic              vld_i,
   output logic [DATA_W-1:0] data_o,
   output logic              vld_o,
   output logic              busy,
   output logic              ovf
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int PW    = DATA_W + GAIN_W + 1;

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_MAC, S_OUT} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0]        x_q, x_d;
   logic [GAIN_W-1:0]        g_q, g_d;
   logic                     en_q, en_d;
   logic signed [PW-1:0]     p_q, p_d;
   logic [DATA_W-1:0]        data_o_q, data_o_d;
   logic                     vld_o_q, vld_o_d;
   logic                     ovf_q, ovf_d;

   logic [DATA_W-1:0]        mem [DEPTH];
   logic [DATA_W-1:0]        rd_data_q;
   logic                     we;
   logic [ADDR_W-1:0]        waddr;
   logic [DATA_W-1:0]        wdata;

   logic [ADDR_W-1:0]        d_eff;
   logic signed [PW-1:0]     g_ext, r_ext;
   logic [DATA_W:0]          s;
   logic [DATA_W-1:0]        y, out_val;
   logic                     unused_ok;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_addr_d = rd_addr_q;
      x_d       = x_q;
      g_d       = g_q;
      en_d      = en_q;
      p_d       = p_q;
      data_o_d  = data_o_q;
      vld_o_d   = 1'b0;
      ovf_d     = ovf_q;
      we        = 1'b0;
      waddr     = wr_ptr_q;
      wdata     = '0;

      d_eff = (delay == '0) ? ADDR_W'(1) : delay;
      g_ext = {{(DATA_W + 1){1'b0}}, g_q};
      r_ext = {{(GAIN_W + 1){rd_data_q[DATA_W-1]}}, rd_data_q};

      // p_q[PW-1:GAIN_W] is exactly p >>> GAIN_W at DATA_W+1 bits; the sum cannot overflow that width
      s = {x_q[DATA_W-1], x_q} + p_q[PW-1:GAIN_W];
`ifdef ECHO_SAT_EN
      if (s[DATA_W] != s[DATA_W-1])
         y = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         y = s[DATA_W-1:0];
`else
      y = s[DATA_W-1:0];
`endif
      out_val   = en_q ? y : x_q;
      unused_ok = ^{p_q[GAIN_W-1:0], s[DATA_W]};

      if (vld_i && state_q != S_IDLE)
         ovf_d = 1'b1;

      case (state_q)
         S_CLEAR: begin
            we        = 1'b1;
            waddr     = clr_cnt_q;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1)
               state_d = S_IDLE;
         end
         S_IDLE: begin
            if (vld_i) begin
               x_d       = data_i;
               g_d       = gain;
               en_d      = en;
               rd_addr_d = wr_ptr_q - d_eff;
               state_d   = S_RD;
            end
         end
         S_RD:  state_d = S_MAC;
         S_MAC: begin
            p_d     = g_ext * r_ext;
            state_d = S_OUT;
         end
         S_OUT: begin
            data_o_d = out_val;
            vld_o_d  = 1'b1;
            we       = 1'b1;
            waddr    = wr_ptr_q;
            wdata    = out_val;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_CLEAR;
      endcase

      // a reset landing mid-sample must not commit that sample to the history
      if (!rst_n)
         we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_addr_q <= '0;
         x_q       <= '0;
         g_q       <= '0;
         en_q      <= 1'b0;
         p_q       <= '0;
         data_o_q  <= '0;
         vld_o_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_addr_q <= rd_addr_d;
         x_q       <= x_d;
         g_q       <= g_d;
         en_q      <= en_d;
         p_q       <= p_d;
         data_o_q  <= data_o_d;
         vld_o_q   <= vld_o_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rd_data_q <= mem[rd_addr_q];
   end

   assign data_o = data_o_q;
   assign vld_o  = vld_o_q;
   assign ovf    = ovf_q;
   assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_eff_echo.sv
// Self-checking bench for eff_echo: random and directed samples against a history-array model.
module tb_eff_echo;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 12;
   localparam int GAIN_W = 8;
   localparam int DEPTH  = 4096;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [ADDR_W-1:0] delay = '0;
   logic [GAIN_W-1:0] gain = '0;
   logic [DATA_W-1:0] data_i = '0;
   logic              vld_i = 1'b0;
   logic [DATA_W-1:0] data_o;
   logic              vld_o;
   logic              busy;
   logic              ovf;

   int checks = 0;
   int errors = 0;
   int vld_cnt = 0;

   longint      hist [DEPTH];
   int unsigned wp;

   eff_echo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .delay(delay), .gain(gain),
      .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o),
      .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (vld_o === 1'b1) vld_cnt++;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void model_reset();
      foreach (hist[i]) hist[i] = 0;
      wp = 0;
   endfunction

   // y[n] = x[n] + floor(gain * y[n-d] / 256), history holds whatever was emitted
   function automatic longint model_step(longint x, bit e, int unsigned d, int unsigned g);
      int unsigned de;
      longint h, s, y, o;
      de = (d == 0) ? 1 : d;
      h  = hist[(wp + DEPTH - de) % DEPTH];
      s  = x + ((longint'(g) * h) >>> 8);
`ifdef ECHO_SAT_EN
      if (s > 8388607) y = 8388607;
      else if (s < -8388608) y = -8388608;
      else y = s;
`else
      y = s & 64'hFFFFFF;
      if (y >= 8388608) y = y - 16777216;
`endif
      o = e ? y : x;
      hist[wp] = o;
      wp = (wp + 1) % DEPTH;
      return o;
   endfunction

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 10000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      vld_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      count_busy(n);
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL reset_clear_len: got %0d busy cycles expected %0d", n, DEPTH);
      end
   endtask

   task automatic send(input longint x, input bit e, input int unsigned d, input int unsigned g,
                       input string name, output logic [DATA_W-1:0] got);
      longint            ex;
      logic [DATA_W-1:0] ex24;
      int                lat;
      ex   = model_step(x, e, d, g);
      ex24 = DATA_W'(ex);
      @(negedge clk);
      data_i = DATA_W'(x);
      en     = e;
      delay  = ADDR_W'(d);
      gain   = GAIN_W'(g);
      vld_i  = 1'b1;
      @(negedge clk);
      vld_i  = 1'b0;
      en     = 1'($urandom);
      delay  = ADDR_W'($urandom);
      gain   = GAIN_W'($urandom);
      data_i = DATA_W'($urandom);
      lat = 1;
      while (vld_o !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles expected 4", name, lat);
      end
      got = data_o;
      checks++;
      if (data_o !== ex24) begin
         errors++;
         $display("FAIL %s data: got %0d expected %0d", name, $signed(data_o), $signed(ex24));
      end
      @(negedge clk);
      checks++;
      if (vld_o !== 1'b0 || data_o !== got) begin
         errors++;
         $display("FAIL %s hold: got vld_o=%b data_o=%0d expected vld_o=0 data_o=%0d",
                  name, vld_o, $signed(data_o), $signed(got));
      end
   endtask

   task automatic test_reset();
      int n, v0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (data_o !== '0 || vld_o !== 1'b0 || ovf !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got data_o=%0d vld_o=%b ovf=%b busy=%b expected 0 0 0 1",
                  data_o, vld_o, ovf, busy);
      end
      rst_n = 1'b1;
      model_reset();
      v0 = vld_cnt;
      n = 0;
      while (busy === 1'b1 && n < 10000) begin
         n++;
         vld_i  = (n == 100);
         data_i = DATA_W'($urandom);
         @(negedge clk);
      end
      vld_i = 1'b0;
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL busy_len: got %0d cycles expected %0d", n, DEPTH);
      end
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL clear_drop_ovf: got %b expected 1", ovf);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (vld_cnt != v0) begin
         errors++;
         $display("FAIL clear_drop_vld: got %0d pulses expected 0", vld_cnt - v0);
      end
      do_reset();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_reset: got %b expected 0", ovf);
      end
   endtask

   task automatic test_impulse();
      int                exp_tab [10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};
      logic [DATA_W-1:0] got, ex24;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send((i == 0) ? 1000 : 0, 1'b1, 3, 128, "impulse", got);
         ex24 = DATA_W'(exp_tab[i]);
         checks++;
         if (got !== ex24) begin
            errors++;
            $display("FAIL impulse_tab[%0d]: got %0d expected %0d", i, $signed(got), exp_tab[i]);
         end
         repeat (58) @(negedge clk);
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] got, xv;
      longint            x;
      for (int i = 0; i < 8; i++) begin
         x  = i * 1500 - 4000;
         xv = DATA_W'(x);
         send(x, 1'b0, 2, 255, "bypass", got);
         checks++;
         if (got !== xv) begin
            errors++;
            $display("FAIL bypass_eq: got %0d expected %0d", $signed(got), x);
         end
      end
   endtask

   task automatic test_saturation();
      logic [DATA_W-1:0] got, second;
      do_reset();
      second = '0;
      for (int i = 0; i < 4; i++) begin
         send(8388607, 1'b1, 1, 255, "sat", got);
         if (i == 1) second = got;
      end
      checks++;
`ifdef ECHO_SAT_EN
      if (second !== 24'h7FFFFF) begin
         errors++;
         $display("FAIL sat_clip: got %0d expected 8388607", $signed(second));
      end
`else
      if (second[DATA_W-1] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_sign: got %0d expected a negative value", $signed(second));
      end
`endif
   endtask

   task automatic test_delay_zero();
      int                exp_tab [3] = '{1000, 500, 250};
      logic [DATA_W-1:0] got, ex24;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send((i == 0) ? 1000 : 0, 1'b1, 0, 128, "delay0", got);
         ex24 = DATA_W'(exp_tab[i]);
         checks++;
         if (got !== ex24) begin
            errors++;
            $display("FAIL delay0_tab[%0d]: got %0d expected %0d", i, $signed(got), exp_tab[i]);
         end
      end
   endtask

   task automatic test_random();
      logic signed [DATA_W-1:0] r;
      logic [DATA_W-1:0]        got;
      int unsigned              d;
      for (int i = 0; i < 60; i++) begin
         r = DATA_W'($urandom);
         d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 12);
         send(longint'(r), 1'($urandom_range(0, 3) != 0), d, $urandom_range(0, 255), "random", got);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   // second strobe lands 'off' cycles after the first: 1 = RD cycle, 3 = OUT cycle
   task automatic test_drop(input int off);
      logic signed [DATA_W-1:0] x1, x2;
      logic [DATA_W-1:0]        ex24, got;
      int                       v0;
      do_reset();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL drop%0d_ovf_pre: got %b expected 0", off, ovf);
      end
      x1 = DATA_W'($urandom);
      x2 = DATA_W'($urandom);
      ex24 = DATA_W'(model_step(longint'(x1), 1'b1, 2, 200));
      v0 = vld_cnt;
      @(negedge clk);
      data_i = x1; en = 1'b1; delay = 2; gain = 200; vld_i = 1'b1;
      for (int c = 1; c <= off; c++) begin
         @(negedge clk);
         vld_i = (c == off);
         data_i = x2;
      end
      @(negedge clk);
      vld_i = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (vld_cnt - v0 != 1) begin
         errors++;
         $display("FAIL drop%0d_count: got %0d pulses expected 1", off, vld_cnt - v0);
      end
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL drop%0d_ovf: got %b expected 1", off, ovf);
      end
      checks++;
      if (data_o !== ex24) begin
         errors++;
         $display("FAIL drop%0d_data: got %0d expected %0d", off, $signed(data_o), $signed(ex24));
      end
      send(1234, 1'b1, 1, 128, "after_drop", got);
   endtask

   task automatic test_reset_mid();
      int                       v0, n;
      logic signed [DATA_W-1:0] r;
      logic [DATA_W-1:0]        got;
      v0 = vld_cnt;
      @(negedge clk);
      data_i = 24'd777; en = 1'b1; delay = 1; gain = 255; vld_i = 1'b1;
      @(negedge clk);
      vld_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || vld_o !== 1'b0 || data_o !== '0) begin
         errors++;
         $display("FAIL mid_reset_state: got busy=%b vld_o=%b data_o=%0d expected 1 0 0",
                  busy, vld_o, data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      count_busy(n);
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL mid_reset_clear: got %0d busy cycles expected %0d", n, DEPTH);
      end
      checks++;
      if (vld_cnt != v0) begin
         errors++;
         $display("FAIL mid_reset_vld: got %0d pulses expected 0", vld_cnt - v0);
      end
      for (int i = 0; i < 4; i++) begin
         r = DATA_W'($urandom);
         send(longint'(r), 1'b1, DEPTH - 1 - i, 255, "post_clear", got);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_impulse();
      test_bypass();
      test_random();
      test_saturation();
      test_delay_zero();
      test_drop(1);
      test_drop(3);
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
